// File: rtl/game_pkg.sv
// Shared game types and default constants for the lives tracker, score and HUD blocks.
package game_pkg;

    typedef enum logic [1:0] {
        PLAY,
        COOL,
        OVER
    } lives_state_t;

    localparam int LIVES_W          = 3;
    localparam int LIVES_START_DEF  = 3;
    localparam int INVULN_TICKS_DEF = 120;
    localparam int BLINK_SHIFT_DEF  = 3;

    // Counter wide enough for ticks-1, and always wide enough to own the blink bit.
    function automatic int cnt_width(input int ticks, input int shift);
        int w;
        w = $clog2(ticks);
        if (w < shift + 1) w = shift + 1;
        return w;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter with enable; saturates at zero and flags it.
module tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    assign zero = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !zero) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/lives_tracker.sv
// Lives count, post-hit invulnerability window, game-over and ship draw mask.
// Optional blink of ship_vis during cooldown: define LIVES_BLINK_EN.
module lives_tracker
    import game_pkg::*;
#(
    parameter int LIVES_START  = LIVES_START_DEF,
    parameter int INVULN_TICKS = INVULN_TICKS_DEF,
    parameter int BLINK_SHIFT  = BLINK_SHIFT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pixpulse,
    input  logic               move,
    input  logic               dec_lives,
    input  logic               start,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over,
    output logic               invuln,
    output logic               ship_vis,
    output logic               respawn
);

    localparam int CNT_W = cnt_width(INVULN_TICKS, BLINK_SHIFT);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(INVULN_TICKS - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES_START);
`ifdef LIVES_BLINK_EN
    localparam logic [CNT_W-1:0] BLINK_MASK = CNT_W'(1) << BLINK_SHIFT;
    localparam logic LOAD_VIS = ((LOAD_VAL & BLINK_MASK) == '0);
`endif

    lives_state_t       state, state_n;
    logic [LIVES_W-1:0] lives_n;
    logic               vis_n, respawn_n;
    logic               tick, tmr_en, tmr_load, tmr_zero;
    logic [CNT_W-1:0]   count;

    assign tick      = pixpulse & move;
    assign game_over = (state == OVER);
    assign invuln    = (state == COOL);

    tick_timer #(.W(CNT_W)) u_cool_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (tmr_en),
        .load     (tmr_load),
        .load_val (LOAD_VAL),
        .count    (count),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_n   = state;
        lives_n   = lives;
        vis_n     = ship_vis;
        respawn_n = 1'b0;
        tmr_en    = 1'b0;
        tmr_load  = 1'b0;
        case (state)
            PLAY: begin
                vis_n = 1'b1;
                if (tick && dec_lives) begin
                    if (lives > LIVES_W'(1)) begin
                        lives_n   = lives - LIVES_W'(1);
                        state_n   = COOL;
                        tmr_load  = 1'b1;
                        respawn_n = 1'b1;
`ifdef LIVES_BLINK_EN
                        vis_n = LOAD_VIS;
`endif
                    end else begin
                        lives_n = '0;
                        state_n = OVER;
                        vis_n   = 1'b0;
                    end
                end
            end
            COOL: begin
                // The expiry tick swallows any hit; the following tick may hit.
                if (tick) begin
                    if (tmr_zero) begin
                        state_n = PLAY;
                        vis_n   = 1'b1;
                    end else begin
                        tmr_en = 1'b1;
`ifdef LIVES_BLINK_EN
                        vis_n = (((count - CNT_W'(1)) & BLINK_MASK) == '0);
`else
                        vis_n = 1'b1;
`endif
                    end
                end
            end
            OVER: begin
                vis_n = 1'b0;
                if (pixpulse && start) begin
                    lives_n   = LIVES_INIT;
                    state_n   = PLAY;
                    respawn_n = 1'b1;
                    vis_n     = 1'b1;
                end
            end
            default: begin
                state_n = PLAY;
                vis_n   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= PLAY;
            lives    <= LIVES_INIT;
            ship_vis <= 1'b1;
            respawn  <= 1'b0;
        end else begin
            state    <= state_n;
            lives    <= lives_n;
            ship_vis <= vis_n;
            respawn  <= respawn_n;
        end
    end

    // Outside cooldown the timer always rests at zero, so the next load starts clean.
    a_idle_timer_zero: assert property (@(posedge clk) disable iff (rst)
        (state != COOL) |-> (count == '0));

endmodule

// File: tb/tb_lives_tracker.sv
// Scoreboard bench for lives_tracker: stimulus queues expected outputs, a monitor checks them on each pixpulse edge.
module tb_lives_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pixpulse = 1'b0;
    logic       move = 1'b0;
    logic       dec_lives = 1'b0;
    logic       start = 1'b0;
    logic [2:0] lives;
    logic       game_over, invuln, ship_vis, respawn;

    typedef struct packed {
        logic [2:0] lv;
        logic       go;
        logic       inv;
        logic       vis;
        logic       resp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   resp_cnt = 0;
    int   ec = 0;
    int   div = 0;

    lives_tracker #(.LIVES_START(3), .INVULN_TICKS(120), .BLINK_SHIFT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .pixpulse  (pixpulse),
        .move      (move),
        .dec_lives (dec_lives),
        .start     (start),
        .lives     (lives),
        .game_over (game_over),
        .invuln    (invuln),
        .ship_vis  (ship_vis),
        .respawn   (respawn)
    );

    always #5 clk = ~clk;

    // pixpulse changes on the falling edge so it is stable at every rising edge
    always @(negedge clk) begin
        div = (div + 1) % 4;
        pixpulse = (div == 0);
    end

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic vis_of(input int c);
        logic [31:0] v;
        v = c;
`ifdef LIVES_BLINK_EN
        return ~v[3];
`else
        return 1'b1 | v[3];
`endif
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (pixpulse) begin
                #1;
                if (respawn) resp_cnt++;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("lives", lives, e.lv);
                    chk("game_over", game_over, e.go);
                    chk("invuln", invuln, e.inv);
                    chk("ship_vis", ship_vis, e.vis);
                    chk("respawn", respawn, e.resp);
                end
            end else begin
                #1;
                chk("respawn_width", respawn, 0);
            end
        end
    end

    task automatic step(input logic m, input logic d, input logic s, input exp_t e);
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #7;
            if (pixpulse) break;
            n++;
            if (n > 8) begin
                $display("FAIL pixpulse_wait got 0 expected 1");
                errors++;
                break;
            end
        end
        move = m;
        dec_lives = d;
        start = s;
        q.push_back(e);
        @(posedge clk);
        #1;
        move = 1'b0;
        dec_lives = 1'b0;
        start = 1'b0;
    endtask

    // One cooldown tick with expected count tracking; ec==0 means this tick exits.
    task automatic cool_tick(input logic d, input logic [2:0] lv);
        if (ec == 0) begin
            step(1'b1, d, 1'b0, '{lv: lv, go: 1'b0, inv: 1'b0, vis: 1'b1, resp: 1'b0});
        end else begin
            ec--;
            step(1'b1, d, 1'b0, '{lv: lv, go: 1'b0, inv: 1'b1, vis: vis_of(ec), resp: 1'b0});
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #3;
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int r0;
        repeat (3) @(negedge clk);
        chk("rst_lives", lives, 3);
        chk("rst_game_over", game_over, 0);
        chk("rst_invuln", invuln, 0);
        chk("rst_ship_vis", ship_vis, 1);
        chk("rst_respawn", respawn, 0);
        rst = 1'b0;

        // single hit then full cooldown
        step(1'b1, 1'b1, 1'b0, '{lv: 3'd2, go: 1'b0, inv: 1'b1, vis: vis_of(119), resp: 1'b1});
        ec = 119;
        repeat (120) cool_tick(1'b0, 3'd2);

        // dec without move, start while playing: no effect
        step(1'b0, 1'b1, 1'b0, '{lv: 3'd2, go: 1'b0, inv: 1'b0, vis: 1'b1, resp: 1'b0});
        step(1'b0, 1'b1, 1'b1, '{lv: 3'd2, go: 1'b0, inv: 1'b0, vis: 1'b1, resp: 1'b0});
        step(1'b1, 1'b0, 1'b1, '{lv: 3'd2, go: 1'b0, inv: 1'b0, vis: 1'b1, resp: 1'b0});

        // second hit, dec held through cooldown, then last life lost
        step(1'b1, 1'b1, 1'b0, '{lv: 3'd1, go: 1'b0, inv: 1'b1, vis: vis_of(119), resp: 1'b1});
        ec = 119;
        repeat (120) cool_tick(1'b1, 3'd1);
        step(1'b1, 1'b1, 1'b0, '{lv: 3'd0, go: 1'b1, inv: 1'b0, vis: 1'b0, resp: 1'b0});
        step(1'b1, 1'b1, 1'b0, '{lv: 3'd0, go: 1'b1, inv: 1'b0, vis: 1'b0, resp: 1'b0});
        step(1'b0, 1'b0, 1'b0, '{lv: 3'd0, go: 1'b1, inv: 1'b0, vis: 1'b0, resp: 1'b0});

        // restart beats a simultaneous hit
        step(1'b1, 1'b1, 1'b1, '{lv: 3'd3, go: 1'b0, inv: 1'b0, vis: 1'b1, resp: 1'b1});

        // dec held for 130 ticks: hits on tick 0 and tick 121 only
        drain();
        r0 = resp_cnt;
        step(1'b1, 1'b1, 1'b0, '{lv: 3'd2, go: 1'b0, inv: 1'b1, vis: vis_of(119), resp: 1'b1});
        ec = 119;
        repeat (120) cool_tick(1'b1, 3'd2);
        step(1'b1, 1'b1, 1'b0, '{lv: 3'd1, go: 1'b0, inv: 1'b1, vis: vis_of(119), resp: 1'b1});
        ec = 119;
        repeat (8) cool_tick(1'b1, 3'd1);
        drain();
        chk("respawn_pulses", resp_cnt - r0, 2);

        // async reset with count at 50
        repeat (61) cool_tick(1'b0, 3'd1);
        drain();
        chk("pre_rst_count", ec, 50);
        chk("pre_rst_invuln", invuln, 1);
        rst = 1'b1;
        #1;
        chk("async_lives", lives, 3);
        chk("async_invuln", invuln, 0);
        chk("async_ship_vis", ship_vis, 1);
        chk("async_game_over", game_over, 0);
        @(negedge clk);
        rst = 1'b0;

        // clean hit after reset starts a fresh cooldown
        step(1'b1, 1'b1, 1'b0, '{lv: 3'd2, go: 1'b0, inv: 1'b1, vis: vis_of(119), resp: 1'b1});
        ec = 119;
        repeat (9) cool_tick(1'b0, 3'd2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
